cache_line_xfer: RTL and testbench

Per-cache line transfer engine sitting directly upstream of one request port of the AXI controller. It accepts a line miss from an L1 cache, optionally writes back a dirty 512-bit victim, then refills the requested 512-bit line. It drives the controller's request, beat-push and FIFO-drain interface, and returns the refilled line to the cache in a single pulse. One instance serves the I-cache port and one serves the D-cache port.

---
 rtl/cache_line_xfer_if.sv | 28 ++
 rtl/cache_line_xfer.sv | 163 ++++++++++++++++
 tb/tb_cache_line_xfer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_xfer_if.sv
// Controller-side request / beat-push / FIFO-drain bus of one cache line transfer engine.
// master = transfer engine, slave = AXI controller port.
interface cache_line_xfer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int BEAT_BITS  = 64
);
    logic                  axi_req;
    logic                  rw_req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BEAT_BITS-1:0]  data;
    logic [7:0]            rw_len;
    logic                  axi_grant;
    logic                  axi_done;
    logic [BEAT_BITS-1:0]  data_i;
    logic [8:0]            fifo_idx;
    logic                  fifo_wen;
    logic                  fifo_done;

    modport master (
        output axi_req, rw_req, addr, data, rw_len, fifo_idx, fifo_wen, fifo_done,
        input  axi_grant, axi_done, data_i
    );

    modport slave (
        input  axi_req, rw_req, addr, data, rw_len, fifo_idx, fifo_wen, fifo_done,
        output axi_grant, axi_done, data_i
    );
endinterface

// File: rtl/cache_line_xfer.sv
// Cache line transfer engine: optional 8-beat victim writeback, then 8-beat line refill,
// driving one request port of the AXI controller.
module cache_line_xfer #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BITS  = 512,
    parameter int BEAT_BITS  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic                  miss_wb,
    input  logic                  miss_rd,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [LINE_BITS-1:0]  victim_line,
    input  logic [ADDR_WIDTH-1:0] refill_addr,
    output logic                  busy,
    output logic                  refill_valid,
    output logic [LINE_BITS-1:0]  refill_line,
    output logic                  wb_done,
    cache_line_xfer_if.master     ctl
);
    typedef enum logic [3:0] {
        IDLE, WB_REQ, WB_FILL, WB_WAIT, WB_REL, RD_REQ, RD_WAIT, RD_DRAIN, RD_REL
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(63);

    state_e                state_q;
    logic [2:0]            k_q;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [LINE_BITS-1:0]  victim_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  refill_valid_q;
    logic [LINE_BITS-1:0]  refill_line_q;
    logic                  wb_done_q;
    logic                  axi_req_q;
    logic                  rw_req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  fifo_wen_q;
    logic                  fifo_done_q;
    logic                  done_rise;

    // A done level left high from an earlier burst must not complete the current one.
    assign done_rise = ctl.axi_done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            k_q            <= '0;
            rd_q           <= 1'b0;
            rd_addr_q      <= '0;
            victim_q       <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            refill_valid_q <= 1'b0;
            refill_line_q  <= '0;
            wb_done_q      <= 1'b0;
            axi_req_q      <= 1'b0;
            rw_req_q       <= 1'b0;
            addr_q         <= '0;
            fifo_wen_q     <= 1'b0;
            fifo_done_q    <= 1'b0;
        end else begin
            done_q         <= ctl.axi_done;
            refill_valid_q <= 1'b0;
            wb_done_q      <= 1'b0;
            fifo_done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_valid && (miss_wb || miss_rd)) begin
                        rd_q      <= miss_rd;
                        rd_addr_q <= refill_addr & LINE_MASK;
                        victim_q  <= victim_line;
                        busy_q    <= 1'b1;
                        axi_req_q <= 1'b1;
                        rw_req_q  <= miss_wb;
                        addr_q    <= miss_wb ? (victim_addr & LINE_MASK)
                                             : (refill_addr & LINE_MASK);
                        state_q   <= miss_wb ? WB_REQ : RD_REQ;
                    end
                end
                WB_REQ: begin
                    if (ctl.axi_grant) begin
                        k_q        <= '0;
                        fifo_wen_q <= 1'b1;
                        state_q    <= WB_FILL;
                    end
                end
                WB_FILL: begin
                    if (k_q == 3'd7) begin
                        k_q        <= '0;
                        fifo_wen_q <= 1'b0;
                        state_q    <= WB_WAIT;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                WB_WAIT: begin
                    if (done_rise) begin
                        axi_req_q   <= 1'b0;
                        fifo_done_q <= 1'b1;
                        wb_done_q   <= ~rd_q;
                        state_q     <= WB_REL;
                    end
                end
                WB_REL: begin
                    if (rd_q) begin
                        axi_req_q <= 1'b1;
                        rw_req_q  <= 1'b0;
                        addr_q    <= rd_addr_q;
                        state_q   <= RD_REQ;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (ctl.axi_grant) begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (done_rise) begin
                        axi_req_q <= 1'b0;
                        k_q       <= '0;
                        state_q   <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    refill_line_q[int'(k_q)*BEAT_BITS +: BEAT_BITS] <= ctl.data_i;
                    if (k_q == 3'd7) begin
                        k_q            <= '0;
                        fifo_done_q    <= 1'b1;
                        refill_valid_q <= 1'b1;
                        state_q        <= RD_REL;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                RD_REL: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign refill_valid  = refill_valid_q;
    assign refill_line   = refill_line_q;
    assign wb_done       = wb_done_q;
    assign ctl.axi_req   = axi_req_q;
    assign ctl.rw_req    = rw_req_q;
    assign ctl.addr      = addr_q;
    assign ctl.rw_len    = 8'd7;
    assign ctl.fifo_wen  = fifo_wen_q;
    assign ctl.fifo_done = fifo_done_q;
    assign ctl.data      = (state_q == WB_FILL) ? victim_q[int'(k_q)*BEAT_BITS +: BEAT_BITS] : '0;
    assign ctl.fifo_idx  = (state_q == RD_DRAIN) ? {k_q, 6'b0} : '0;
endmodule

// File: tb/tb_cache_line_xfer.sv
// Bench for cache_line_xfer: vector table of misses against a behavioural controller,
// scoreboard queues checked by a negedge monitor, plus stale-done and reset-abort sequences.
module tb_cache_line_xfer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_valid = 1'b0;
    logic         miss_wb = 1'b0;
    logic         miss_rd = 1'b0;
    logic [63:0]  victim_addr = '0;
    logic [511:0] victim_line = '0;
    logic [63:0]  refill_addr = '0;
    logic         busy;
    logic         refill_valid;
    logic [511:0] refill_line;
    logic         wb_done;
    logic [63:0]  cur_rbase = '0;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;

    cache_line_xfer_if #(.ADDR_WIDTH(64), .BEAT_BITS(64)) bus ();

    cache_line_xfer #(.ADDR_WIDTH(64), .LINE_BITS(512), .BEAT_BITS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_wb      (miss_wb),
        .miss_rd      (miss_rd),
        .victim_addr  (victim_addr),
        .victim_line  (victim_line),
        .refill_addr  (refill_addr),
        .busy         (busy),
        .refill_valid (refill_valid),
        .refill_line  (refill_line),
        .wb_done      (wb_done),
        .ctl          (bus)
    );

    always #5 clk = ~clk;

    // Controller FIFO model: beat k of the current refill is rbase*(k+1).
    always_comb bus.data_i = cur_rbase * (64'(bus.fifo_idx >> 6) + 64'd1);

    typedef struct {
        logic        rw;
        logic [63:0] addr;
    } req_t;

    typedef struct {
        bit          wb;
        bit          rd;
        logic [63:0] vaddr;
        logic [63:0] raddr;
        logic [63:0] vbase;
        logic [63:0] rbase;
        int          gdel;
        int          ddel;
        logic [63:0] exp_waddr;
        logic [63:0] exp_raddr;
    } vec_t;

    req_t         q_req[$];
    logic [63:0]  q_beat[$];
    logic [511:0] q_line[$];
    bit           q_wbd[$];
    req_t         m_req;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.axi_req && bus.axi_grant) begin
            chk("req_expected", 512'(q_req.size() != 0), 512'd1);
            if (q_req.size() != 0) begin
                m_req = q_req.pop_front();
                chk("rw_req", bus.rw_req, m_req.rw);
                chk("addr", bus.addr, m_req.addr);
                chk("rw_len", bus.rw_len, 8'd7);
            end
        end
        if (bus.fifo_wen) begin
            chk("beat_expected", 512'(q_beat.size() != 0), 512'd1);
            if (q_beat.size() != 0) chk("wdata", bus.data, q_beat.pop_front());
            chk("wr_rw_req", bus.rw_req, 1'b1);
        end
        if (refill_valid) begin
            chk("line_expected", 512'(q_line.size() != 0), 512'd1);
            if (q_line.size() != 0) chk("refill_line", refill_line, q_line.pop_front());
            chk("rv_with_fifo_done", bus.fifo_done, 1'b1);
        end
        if (wb_done) begin
            chk("wbd_expected", 512'(q_wbd.size() != 0), 512'd1);
            if (q_wbd.size() != 0) void'(q_wbd.pop_front());
            chk("wbd_with_fifo_done", bus.fifo_done, 1'b1);
        end
        if (bus.fifo_done) begin
            fd_cnt++;
            chk("fd_req_low", bus.axi_req, 1'b0);
        end
        if (busy === 1'b0) chk("idle_req_low", bus.axi_req, 1'b0);
    end

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 1'b0);
        chk("rst_refill_valid", refill_valid, 1'b0);
        chk("rst_refill_line", refill_line, 512'd0);
        chk("rst_wb_done", wb_done, 1'b0);
        chk("rst_axi_req", bus.axi_req, 1'b0);
        chk("rst_rw_req", bus.rw_req, 1'b0);
        chk("rst_addr", bus.addr, 64'd0);
        chk("rst_data", bus.data, 64'd0);
        chk("rst_rw_len", bus.rw_len, 8'd7);
        chk("rst_fifo_idx", bus.fifo_idx, 9'd0);
        chk("rst_fifo_wen", bus.fifo_wen, 1'b0);
        chk("rst_fifo_done", bus.fifo_done, 1'b0);
    endtask

    // Behavioural controller for one burst: grant after gdel cycles, then a fresh done edge.
    task automatic ctrl(input int gdel, input int ddel, input bit stale, input bit keep);
        int n = 0;
        while (!bus.axi_req && n < 200) begin
            step();
            n++;
        end
        chk("req_seen", bus.axi_req, 1'b1);
        repeat (gdel) step();
        bus.axi_grant = 1'b1;
        step();
        bus.axi_grant = 1'b0;
        if (stale) begin
            for (int i = 0; i < 10; i++) begin
                chk("stale_still_waiting", bus.axi_req, 1'b1);
                step();
            end
            bus.axi_done = 1'b0;
            step();
        end else begin
            repeat (ddel) step();
        end
        bus.axi_done = 1'b1;
        n = 0;
        while (!bus.fifo_done && n < 300) begin
            step();
            n++;
        end
        chk("fifo_done_seen", bus.fifo_done, 1'b1);
        if (!keep) bus.axi_done = 1'b0;
    endtask

    task automatic load_miss(input vec_t v);
        req_t         r;
        logic [511:0] line = '0;
        if (v.wb) begin
            r.rw = 1'b1;
            r.addr = v.exp_waddr;
            q_req.push_back(r);
            for (int k = 0; k < 8; k++) q_beat.push_back(v.vbase + 64'(k));
            if (!v.rd) q_wbd.push_back(1'b1);
        end
        if (v.rd) begin
            r.rw = 1'b0;
            r.addr = v.exp_raddr;
            q_req.push_back(r);
            for (int k = 0; k < 8; k++) line[k*64 +: 64] = v.rbase * 64'(k + 1);
            q_line.push_back(line);
        end
        for (int k = 0; k < 8; k++) victim_line[k*64 +: 64] = v.vbase + 64'(k);
        victim_addr = v.vaddr;
        refill_addr = v.raddr;
        miss_wb     = v.wb;
        miss_rd     = v.rd;
        cur_rbase   = v.rbase;
        miss_valid  = 1'b1;
        chk("busy_before_accept", busy, 1'b0);
        step();
        miss_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit stale, input bit keep);
        load_miss(v);
        if (!v.wb && !v.rd) begin
            chk("ignored_busy", busy, 1'b0);
            step();
            chk("ignored_req", bus.axi_req, 1'b0);
            return;
        end
        chk("busy_rise", busy, 1'b1);
        if (v.wb) begin
            ctrl(v.gdel, v.ddel, 1'b0, 1'b0);
            chk("wb_rel_no_rv", refill_valid, 1'b0);
            chk("wb_done_at_rel", wb_done, !v.rd);
            chk("busy_at_rel", busy, 1'b1);
        end
        if (v.rd) begin
            ctrl(v.gdel, v.ddel, stale, keep);
            chk("rv_pulse", refill_valid, 1'b1);
        end
        step();
        chk("busy_fall", busy, 1'b0);
        chk("pulses_end", refill_valid | wb_done, 1'b0);
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        bus.axi_grant = 1'b0;
        bus.axi_done  = 1'b0;
        //          wb    rd    vaddr                  raddr                  vbase                  rbase                  gdel ddel exp_waddr              exp_raddr
        vecs[0] = '{1'b0, 1'b1, 64'h0,                 64'h0000_0000_8000_0047, 64'h0,               64'h1111,              2, 20, 64'h0,                 64'h0000_0000_8000_0040};
        vecs[1] = '{1'b1, 1'b1, 64'h1234_5678_9ABC_DEFF, 64'h0000_0000_0000_1000, 64'hA0,            64'h0123_4567_89AB_CDEF, 1, 12, 64'h1234_5678_9ABC_DEC0, 64'h0000_0000_0000_1000};
        vecs[2] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 64'h5555_0000_0000_0000, 64'h0,              0, 15, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0};
        vecs[3] = '{1'b0, 1'b0, 64'h40,                64'h80,                 64'h1,                 64'h2,                 0, 1,  64'h0,                 64'h0};
        vecs[4] = '{1'b0, 1'b1, 64'h0,                 64'h0000_0000_0000_003F, 64'h0,               64'hDEAD_BEEF,         0, 1,  64'h0,                 64'h0};
        vecs[5] = '{1'b1, 1'b1, 64'h0000_0000_0000_0040, 64'hFFFF_FFFF_FFFF_FFC1, 64'hCAFE_0000,     64'h7,                 3, 30, 64'h0000_0000_0000_0040, 64'hFFFF_FFFF_FFFF_FFC0};

        repeat (3) step();
        chk_reset_outputs();
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, 1'b0);

        // Stale done: leave done high after one read, next read must wait for a fresh edge.
        rv = vecs[4];
        run_vec(rv, 1'b0, 1'b1);
        rv.raddr = 64'h0000_0000_0000_2010;
        rv.exp_raddr = 64'h0000_0000_0000_2000;
        rv.rbase = 64'h0BAD_F00D;
        run_vec(rv, 1'b1, 1'b0);

        // Reset while the fourth writeback beat (k=3) is on the bus.
        begin
            int n = 0;
            int fdc;
            load_miss(vecs[1]);
            while (!bus.axi_req && n < 50) begin
                step();
                n++;
            end
            bus.axi_grant = 1'b1;
            step();
            bus.axi_grant = 1'b0;
            n = 0;
            while (!(bus.fifo_wen && bus.data == 64'hA3) && n < 50) begin
                step();
                n++;
            end
            chk("k3_reached", bus.data, 64'hA3);
            fdc = fd_cnt;
            rst = 1'b1;
            step();
            chk_reset_outputs();
            rst = 1'b0;
            q_req.delete();
            q_beat.delete();
            q_line.delete();
            q_wbd.delete();
            repeat (5) step();
            chk("no_fifo_done_after_abort", 512'(fd_cnt), 512'(fdc));
            chk("idle_after_abort", busy, 1'b0);
        end

        run_vec(vecs[1], 1'b0, 1'b0);

        chk("q_req_empty", 512'(q_req.size()), 512'd0);
        chk("q_beat_empty", 512'(q_beat.size()), 512'd0);
        chk("q_line_empty", 512'(q_line.size()), 512'd0);
        chk("q_wbd_empty", 512'(q_wbd.size()), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
